// File: rtl/vend_ctrl_multi_if.sv
// vend_ctrl_multi_if: button, price, hopper and status signals of the multi-item vending controller
interface vend_ctrl_multi_if #(
    parameter int NUM_ITEMS = 4,
    parameter int SEL_W     = 2,
    parameter int CREDIT_W  = 8,
    parameter int STOCK_W   = 4
);
    logic                          coin1_p;
    logic                          coin2_p;
    logic                          coin5_p;
    logic                          purchase_p;
    logic                          cancel_p;
    logic                          restock;
    logic [SEL_W-1:0]              item_sel;
    logic [NUM_ITEMS*CREDIT_W-1:0] price_vec;
    logic                          change_ack;
    logic [CREDIT_W-1:0]           credit;
    logic [STOCK_W-1:0]            stock_level;
    logic                          vend_pulse;
    logic [SEL_W-1:0]              vend_item;
    logic                          change_req;
    logic [1:0]                    change_denom;
    logic                          coin_reject;
    logic                          error_flag;
    logic [1:0]                    error_code;
    logic [2:0]                    state;

    modport master (
        output coin1_p, coin2_p, coin5_p, purchase_p, cancel_p, restock, item_sel, price_vec, change_ack,
        input  credit, stock_level, vend_pulse, vend_item, change_req, change_denom, coin_reject,
               error_flag, error_code, state
    );

    modport slave (
        input  coin1_p, coin2_p, coin5_p, purchase_p, cancel_p, restock, item_sel, price_vec, change_ack,
        output credit, stock_level, vend_pulse, vend_item, change_req, change_denom, coin_reject,
               error_flag, error_code, state
    );
endinterface

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: N-item vending controller with per-item stock, saturating credit and
// greedy 5/2/1 change payout over a req/ack hopper handshake.
// Optional escrow timeout (auto refund of idle credit) enabled by defining ESCROW_TIMEOUT_EN.
module vend_ctrl_multi #(
    parameter int NUM_ITEMS   = 4,
    parameter int SEL_W       = 2,
    parameter int CREDIT_W    = 8,
    parameter int MAX_CREDIT  = 99,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 5,
    parameter int AUTO_CHANGE = 1
`ifdef ESCROW_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    vend_ctrl_multi_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        VEND     = 3'd2,
        CHANGE   = 3'd3,
        WAIT_ACK = 3'd4,
        ERROR    = 3'd5
    } state_t;

    localparam logic [CREDIT_W:0]            MAX_C  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0]           INIT_S = STOCK_W'(INIT_STOCK);
    localparam logic [NUM_ITEMS*STOCK_W-1:0] FULL   = {NUM_ITEMS{INIT_S}};

    state_t                       r_state, w_next;
    logic [CREDIT_W-1:0]          r_credit, w_credit, w_avail, w_price, w_pay;
    logic [NUM_ITEMS*STOCK_W-1:0] r_stock, w_stock;
    logic [STOCK_W-1:0]           w_stock_sel;
    logic [1:0]                   r_denom, w_denom, r_err, w_err, w_code;
    logic [3:0]                   w_coin_amt;
    logic [CREDIT_W:0]            w_sum;
    logic                         w_coin, w_fits, w_sel_ok, w_timeout;

    assign w_coin      = bus.coin1_p | bus.coin2_p | bus.coin5_p;
    assign w_coin_amt  = (bus.coin5_p ? 4'd5 : 4'd0) + (bus.coin2_p ? 4'd2 : 4'd0) + {3'd0, bus.coin1_p};
    assign w_sum       = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_amt);
    assign w_fits      = w_sum <= MAX_C;
    assign w_avail     = (w_coin && w_fits) ? w_sum[CREDIT_W-1:0] : r_credit;
    assign w_sel_ok    = 32'(bus.item_sel) < NUM_ITEMS;
    assign w_price     = w_sel_ok ? bus.price_vec[bus.item_sel*CREDIT_W +: CREDIT_W] : '0;
    assign w_stock_sel = w_sel_ok ? r_stock[bus.item_sel*STOCK_W +: STOCK_W] : '0;
    assign w_code      = r_credit >= CREDIT_W'(5) ? 2'b11 : r_credit >= CREDIT_W'(2) ? 2'b10 : 2'b01;
    assign w_pay       = r_denom == 2'b11 ? CREDIT_W'(5) : r_denom == 2'b10 ? CREDIT_W'(2) : CREDIT_W'(1);

`ifdef ESCROW_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_idle_cnt;
    logic          w_any;
    assign w_any     = w_coin | bus.purchase_p | bus.cancel_p | bus.restock;
    assign w_timeout = r_idle_cnt == TW'(TIMEOUT_CYC);
    // Escrow counter: counts cycles of untouched credit sitting in IDLE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_idle_cnt <= '0;
        else if (r_state == IDLE && r_credit != '0 && !w_any && !w_timeout)
            r_idle_cnt <= r_idle_cnt + 1'b1;
        else
            r_idle_cnt <= '0;
`else
    assign w_timeout = 1'b0;
`endif

    // Next state, credit, stock, payout denomination and error code
    always_comb begin
        w_next   = r_state;
        w_credit = r_credit;
        w_stock  = r_stock;
        w_denom  = r_denom;
        w_err    = r_err;
        case (r_state)
            IDLE: begin
                w_credit = w_avail;
                if (bus.cancel_p && w_avail != '0)
                    w_next = CHANGE;
                else if (bus.purchase_p)
                    w_next = CHECK;
                else if (bus.restock) begin
                    if (w_sel_ok)
                        w_stock[bus.item_sel*STOCK_W +: STOCK_W] = INIT_S;
                end else if (w_timeout)
                    w_next = CHANGE;
            end
            CHECK: begin
                w_next = ERROR;
                if (!w_sel_ok)
                    w_err = 2'b11;
                else if (w_stock_sel == '0)
                    w_err = 2'b10;
                else if (r_credit < w_price)
                    w_err = 2'b01;
                else
                    w_next = VEND;
            end
            VEND: begin
                w_credit = r_credit >= w_price ? r_credit - w_price : '0;
                if (w_sel_ok && w_stock_sel != '0)
                    w_stock[bus.item_sel*STOCK_W +: STOCK_W] = w_stock_sel - 1'b1;
                w_next = (AUTO_CHANGE != 0 && w_credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                w_denom = w_code;
                w_next  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.change_ack) begin
                    w_credit = r_credit >= w_pay ? r_credit - w_pay : '0;
                    w_next   = w_credit != '0 ? CHANGE : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any payout in flight
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_stock  <= FULL;
            r_denom  <= '0;
            r_err    <= '0;
        end else begin
            r_state  <= w_next;
            r_credit <= w_credit;
            r_stock  <= w_stock;
            r_denom  <= w_denom;
            r_err    <= w_err;
        end

    assign bus.credit       = r_credit;
    assign bus.stock_level  = w_stock_sel;
    assign bus.vend_pulse   = r_state == VEND;
    assign bus.vend_item    = r_state == VEND ? bus.item_sel : '0;
    assign bus.change_req   = r_state == WAIT_ACK;
    assign bus.change_denom = r_state == WAIT_ACK ? r_denom : 2'b00;
    assign bus.coin_reject  = w_coin && (r_state != IDLE || !w_fits);
    assign bus.error_flag   = r_state == ERROR;
    assign bus.error_code   = r_err;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: scoreboard bench with a transaction-level vending model
module tb_vend_ctrl_multi;
    localparam int N = 4, SW = 3, CW = 8, STW = 4;

    typedef struct {int kind; int val;} ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fixed_delay = -1;
    int   m_credit = 0;
    int   m_stock[N];
    int   prices[N] = '{3, 4, 6, 2};
    ev_t  q_ev[$];
    bit   q_rej[$];
    logic prev_req = 1'b0;
    logic [1:0] prev_denom = 2'b00;

    always #5 clk = ~clk;

    vend_ctrl_multi_if #(.NUM_ITEMS(N), .SEL_W(SW), .CREDIT_W(CW), .STOCK_W(STW)) bus ();

    vend_ctrl_multi #(.NUM_ITEMS(N), .SEL_W(SW), .CREDIT_W(CW), .STOCK_W(STW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_ev(input int kind, input int val, input string name);
        ev_t e;
        checks++;
        if (q_ev.size() == 0) begin
            errors++;
            $display("FAIL %s: got value %0d with nothing expected", name, val);
        end else begin
            e = q_ev.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL %s: got kind %0d val %0d expected kind %0d val %0d", name, kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (bus.coin_reject) begin
                checks++;
                if (q_rej.size() == 0) begin
                    errors++;
                    $display("FAIL coin_reject: got 1 expected 0");
                end else
                    void'(q_rej.pop_front());
            end
            if (bus.vend_pulse) check_ev(0, int'(bus.vend_item), "vend");
            if (bus.error_flag) check_ev(1, int'(bus.error_code), "error");
            if (bus.change_req && bus.change_ack)
                check_ev(2, bus.change_denom == 2'b11 ? 5 : bus.change_denom == 2'b10 ? 2 :
                            bus.change_denom == 2'b01 ? 1 : -1, "payout");
            if (prev_req && bus.change_req)
                check_val("denom_hold", int'(bus.change_denom), int'(prev_denom));
            prev_req   = bus.change_req;
            prev_denom = bus.change_denom;
        end
    end

    // Hopper: acknowledges each request after a (random or fixed) delay
    initial begin
        bus.change_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.change_req) begin : ack_blk
                int d;
                d = fixed_delay >= 0 ? fixed_delay : int'($urandom_range(0, 3));
                repeat (d) begin @(posedge clk); #1; end
                bus.change_ack = 1'b1;
                @(posedge clk); #1;
                bus.change_ack = 1'b0;
            end
        end
    end

    task automatic drive(input bit c1, c2, c5, pu, ca, rs);
        {bus.coin1_p, bus.coin2_p, bus.coin5_p, bus.purchase_p, bus.cancel_p, bus.restock} = {c1, c2, c5, pu, ca, rs};
        @(posedge clk); #1;
        {bus.coin1_p, bus.coin2_p, bus.coin5_p, bus.purchase_p, bus.cancel_p, bus.restock} = '0;
    endtask

    task automatic payout();
        while (m_credit > 0) begin
            int d;
            d = m_credit >= 5 ? 5 : m_credit >= 2 ? 2 : 1;
            q_ev.push_back('{2, d});
            m_credit -= d;
        end
    endtask

    task automatic add_coins(input bit c1, c2, c5);
        int a;
        a = int'(c1) + 2 * int'(c2) + 5 * int'(c5);
        if (a > 0) begin
            if (m_credit + a > 99) q_rej.push_back(1'b1);
            else m_credit += a;
        end
    endtask

    task automatic do_coin(input bit c1, c2, c5);
        add_coins(c1, c2, c5);
        drive(c1, c2, c5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_purchase(input int item, input bit c1, c2, c5, input int late);
        add_coins(c1, c2, c5);
        if (item >= N) q_ev.push_back('{1, 3});
        else if (m_stock[item] == 0) q_ev.push_back('{1, 2});
        else if (m_credit < prices[item]) q_ev.push_back('{1, 1});
        else begin
            q_ev.push_back('{0, item});
            m_stock[item]--;
            m_credit -= prices[item];
            payout();
        end
        bus.item_sel = SW'(item);
        drive(c1, c2, c5, 1'b1, 1'b0, 1'b0);
        if (late > 0) begin
            if (late == 2) begin @(posedge clk); #1; end
            q_rej.push_back(1'b1);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_cancel();
        if (m_credit > 0) payout();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_restock(input int item);
        if (item < N) m_stock[item] = 5;
        bus.item_sel = SW'(item);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic settle(input string tag);
        int n;
        int sel;
        n = 0;
        while (!(bus.state == 3'd0 && q_ev.size() == 0 && q_rej.size() == 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s timeout: state %0d pending events %0d rejects %0d", tag, bus.state, q_ev.size(), q_rej.size());
            q_ev.delete();
            q_rej.delete();
        end
        sel = int'(bus.item_sel);
        check_val({tag, " credit"}, int'(bus.credit), m_credit);
        check_val({tag, " stock"}, int'(bus.stock_level), sel < N ? m_stock[sel] : 0);
    endtask

    initial begin
        foreach (m_stock[i]) m_stock[i] = 5;
        {bus.coin1_p, bus.coin2_p, bus.coin5_p, bus.purchase_p, bus.cancel_p, bus.restock} = '0;
        bus.item_sel  = '0;
        bus.price_vec = {8'd2, 8'd6, 8'd4, 8'd3};
        repeat (3) @(posedge clk);
        #1;
        check_val("rst state", int'(bus.state), 0);
        check_val("rst credit", int'(bus.credit), 0);
        check_val("rst change_req", int'(bus.change_req), 0);
        check_val("rst vend_pulse", int'(bus.vend_pulse), 0);
        check_val("rst error_flag", int'(bus.error_flag), 0);
        check_val("rst error_code", int'(bus.error_code), 0);
        for (int i = 0; i < 6; i++) begin
            bus.item_sel = SW'(i);
            #1;
            check_val("rst stock", int'(bus.stock_level), i < N ? 5 : 0);
        end
        bus.item_sel = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_coin(1'b0, 1'b0, 1'b1);
        do_purchase(0, 1'b0, 1'b0, 1'b0, 0);
        settle("vend0");

        do_coin(1'b0, 1'b1, 1'b0);
        do_purchase(2, 1'b0, 1'b0, 1'b0, 0);
        settle("poor");
        do_cancel();
        settle("refund2");

        for (int k = 0; k < 5; k++) begin
            do_coin(1'b0, 1'b0, 1'b1);
            do_purchase(1, 1'b0, 1'b0, 1'b0, 0);
            settle("buy1");
        end
        do_purchase(1, 1'b0, 1'b0, 1'b0, 0);
        settle("soldout");
        do_restock(1);
        settle("restock");

        do_purchase(5, 1'b0, 1'b0, 1'b0, 2);
        settle("invalid");
        check_val("invalid error_code", int'(bus.error_code), 3);

        do_coin(1'b1, 1'b1, 1'b0);
        do_purchase(3, 1'b0, 1'b0, 1'b1, 1);
        settle("coin+buy");

        for (int k = 0; k < 150; k++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 9));
            c = int'($urandom_range(0, 7));
            if (r <= 4) do_coin(c[0], c[1], c[2] | (c == 0));
            else if (r <= 6) do_purchase(int'($urandom_range(0, 5)), c[0], c[1], c[2], int'($urandom_range(0, 2)));
            else if (r == 7) do_cancel();
            else if (r == 8) do_restock(int'($urandom_range(0, 5)));
            else do_purchase(int'($urandom_range(0, 5)), 1'b0, 1'b0, 1'b0, 0);
            settle("random");
        end
        do_cancel();
        settle("drain");

        for (int k = 0; k < 19; k++) do_coin(1'b0, 1'b0, 1'b1);
        do_coin(1'b0, 1'b1, 1'b0);
        do_coin(1'b1, 1'b0, 1'b0);
        settle("fill98");
        do_coin(1'b0, 1'b1, 1'b0);
        settle("overflow");
        fixed_delay = 3;
        do_cancel();
        settle("refund98");

        do_purchase(0, 1'b0, 1'b0, 1'b0, 0);
        settle("reject0");
        do_coin(1'b0, 1'b0, 1'b1);
        do_coin(1'b0, 1'b0, 1'b1);
        do_cancel();
        begin : wait_req
            int n;
            n = 0;
            while (!bus.change_req && n < 20) begin @(posedge clk); #1; n++; end
            check_val("req before reset", int'(bus.change_req), 1);
        end
        rst_n = 1'b0;
        #1;
        check_val("async change_req", int'(bus.change_req), 0);
        check_val("async credit", int'(bus.credit), 0);
        check_val("async state", int'(bus.state), 0);
        for (int i = 0; i < N; i++) begin
            bus.item_sel = SW'(i);
            #1;
            check_val("async stock", int'(bus.stock_level), 5);
        end
        q_ev.delete();
        q_rej.delete();
        m_credit = 0;
        foreach (m_stock[i]) m_stock[i] = 5;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fixed_delay = -1;
        @(posedge clk); #1;
        do_coin(1'b0, 1'b0, 1'b1);
        do_purchase(3, 1'b0, 1'b0, 1'b0, 0);
        settle("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised successor to the single-product vending controller. It covers N items, with per-item stock counters, per-item prices supplied on a vector, and saturating credit. A change-dispense FSM pays out leftover credit coin-by-coin (greedy 5/2/1) over a request/acknowledge handshake to the coin hopper. It sits between the button debouncers (single-cycle pulses) and the display/LED/audio logic in vending_machine_top.

Parameters:
NUM_ITEMS, 4, number of selectable items (2..16)
SEL_W, 2, item_sel width, at least clog2(NUM_ITEMS)
CREDIT_W, 8, credit/price width
MAX_CREDIT, 99, credit saturation ceiling
STOCK_W, 4, per-item stock counter width
INIT_STOCK, 5, stock of every item after reset
AUTO_CHANGE, 1, 1 = pay out remaining credit after a vend; 0 = retain credit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
coin1_p / coin2_p / coin5_p  in  1 each  debounced single-cycle coin pulses ($1/$2/$5)
purchase_p  in  1  debounced purchase pulse
cancel_p  in  1  debounced refund request
restock  in  1  refill item_sel to INIT_STOCK
item_sel  in  SEL_W  selected item
price_vec  in  NUM_ITEMS*CREDIT_W  item i price at bits [i*CREDIT_W +: CREDIT_W]
change_ack  in  1  hopper has dispensed current coin
credit  out  CREDIT_W  current credit
stock_level  out  STOCK_W  stock of item_sel; 0 if invalid
vend_pulse  out  1  one-cycle vend strobe
vend_item  out  SEL_W  item vended, valid with vend_pulse
change_req  out  1  coin payout request
change_denom  out  2  01=$1, 10=$2, 11=$5
coin_reject  out  1  one-cycle pulse, coin refused
error_flag  out  1  one-cycle error strobe
error_code  out  2  01 insufficient funds, 10 sold out, 11 invalid item; held until next error
state  out  3  IDLE=0, CHECK=1, VEND=2, CHANGE=3, WAIT_ACK=4, ERROR=5

Behaviour:
- Reset (rst low, async):
  - All outputs 0, state IDLE.
  - Every stock counter set to INIT_STOCK.
  - Any in-flight change_req drops immediately; a refund is abandoned.
- Coins:
  - Accepted only in IDLE. Credit is updated at the same edge as the pulse.
  - If several coin pulses coincide, the sum is taken.
  - If credit + coin > MAX_CREDIT, credit is unchanged and coin_reject pulses.
  - A coin pulse outside IDLE produces coin_reject.
- IDLE, in priority order:
  - cancel_p with credit > 0 goes to CHANGE.
  - purchase_p goes to CHECK.
  - restock refills stock[item_sel] (ignored if item_sel is invalid).
  - A coin and purchase in the same cycle: coin is added first, and CHECK sees the new credit.
- CHECK (1 cycle), first failing test wins:
  - item_sel >= NUM_ITEMS gives error_code 11.
  - stock 0 gives 10.
  - credit < price gives 01.
  - Any failure goes to ERROR. Otherwise go to VEND.
- VEND (1 cycle):
  - vend_pulse=1 and vend_item=item_sel.
  - credit -= price, and stock decrements by 1.
  - Next state is CHANGE if AUTO_CHANGE and the new credit > 0; otherwise IDLE.
- CHANGE:
  - Choose the largest denomination ≤ credit (5, then 2, then 1).
  - Assert change_req with change_denom, then go to WAIT_ACK.
- WAIT_ACK:
  - change_req and change_denom are held stable until change_ack is sampled high.
  - On that edge: credit -= denom and change_req drops. Next state is CHANGE if credit > 0, else IDLE.
  - change_ack outside WAIT_ACK is ignored.
- ERROR (1 cycle):
  - error_flag=1 during the ERROR cycle. Credit and stock are unchanged.
  - Next state IDLE.
- Credit never underflows. The credit register saturates rather than wraps.

Optional Feature:
ESCROW_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT_CYC (default 1000). An idle counter runs in IDLE while credit > 0.
- The counter resets on any coin, purchase, cancel or restock pulse.
- When it reaches TIMEOUT_CYC the FSM enters CHANGE exactly as if cancel_p had been pressed, and error_flag is not raised.
- Undefined: no counter; credit is held indefinitely.

Test Plan:
- Reset, prices {3,4,6,2}, coin5, purchase item0 -> vend_pulse 1 cycle, vend_item=0, stock_level 4; change $2 dispensed as one 10 request; credit 0; back to IDLE.
- credit $2, purchase item2 (price 6) -> ERROR one cycle, error_code=01, credit stays 2, then IDLE.
- Item1 bought 5 times with sufficient credit, then a 6th attempt -> error_code=10; restock -> stock_level 5.
- item_sel=3 with NUM_ITEMS=3 -> error_code=11; coin during ERROR -> coin_reject.
- credit 98, coin2 -> coin_reject, credit 98; cancel -> payouts 5×19 then 2, 1; each request held across a 3-cycle delayed ack.
- rst asserted while in WAIT_ACK -> change_req low immediately, credit 0, every stock = 5.
